// File: rtl/sap_sequencer_if.sv
// sap_sequencer_if
// Groups the datapath-facing signals of the SAP microsequencer.
//   opcode    : IR upper nibble (valid from T3 onward)
//   flag_z/c  : zero / carry flags
//   run, step : free-run level and single-step request
//   out_ack   : output consumer acknowledge
//   ctrl      : 16-bit control word to the datapath
//   stage     : current sequencer state encoding
//   out_valid : high while the OUT wait step waits for out_ack
//   halted    : high in HALT
// The master modport drives opcode/flags/run/step/out_ack; the slave
// modport is the sequencer itself.
interface sap_sequencer_if;
  logic [3:0]  opcode;
  logic        flag_z;
  logic        flag_c;
  logic        run;
  logic        step;
  logic        out_ack;
  logic [15:0] ctrl;
  logic [2:0]  stage;
  logic        out_valid;
  logic        halted;

  modport master (
    output opcode, flag_z, flag_c, run, step, out_ack,
    input  ctrl, stage, out_valid, halted
  );

  modport slave (
    input  opcode, flag_z, flag_c, run, step, out_ack,
    output ctrl, stage, out_valid, halted
  );
endinterface

// File: rtl/sap_sequencer.sv
// sap_sequencer
// Variable-length microsequencer for the extended SAP datapath. Produces
// the 16-bit control word for PC, MAR/RAM, IR, A, B, adder, flags and the
// output register. Instructions end as soon as their microsteps are done;
// supports conditional jumps, an OUT handshake, halt and run/single-step.
// Ports:
//   clk : clock; state advances on the falling edge so ctrl is stable
//         around the datapath's rising edges
//   rst : synchronous active-high reset (sampled on the falling edge)
//   bus : sap_sequencer_if.slave (opcode, flags, run, step, out_ack in;
//         ctrl, stage, out_valid, halted out)
module sap_sequencer (
  input  logic            clk,
  input  logic            rst,
  sap_sequencer_if.slave  bus
);

  typedef enum logic [2:0] {
    ST_T0    = 3'd0,
    ST_T1    = 3'd1,
    ST_T2    = 3'd2,
    ST_T3    = 3'd3,
    ST_T4    = 3'd4,
    ST_T5    = 3'd5,
    ST_PAUSE = 3'd6,
    ST_HALT  = 3'd7
  } state_t;

  localparam logic [3:0] OP_LDA = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_SUB = 4'b0010;
  localparam logic [3:0] OP_JMP = 4'b0100;
  localparam logic [3:0] OP_JZ  = 4'b0101;
  localparam logic [3:0] OP_JC  = 4'b0110;
  localparam logic [3:0] OP_OUT = 4'b1110;
  localparam logic [3:0] OP_HLT = 4'b1111;

  localparam logic [15:0] C_HLT        = 16'h8000;
  localparam logic [15:0] C_PC_INC     = 16'h4000;
  localparam logic [15:0] C_PC_EN      = 16'h2000;
  localparam logic [15:0] C_PC_LOAD    = 16'h1000;
  localparam logic [15:0] C_MEM_LOAD   = 16'h0800;
  localparam logic [15:0] C_MEM_EN     = 16'h0400;
  localparam logic [15:0] C_IR_LOAD    = 16'h0200;
  localparam logic [15:0] C_IR_EN      = 16'h0100;
  localparam logic [15:0] C_A_LOAD     = 16'h0080;
  localparam logic [15:0] C_A_EN       = 16'h0040;
  localparam logic [15:0] C_B_LOAD     = 16'h0020;
  localparam logic [15:0] C_ADDER_SUB  = 16'h0010;
  localparam logic [15:0] C_ADDER_EN   = 16'h0008;
  localparam logic [15:0] C_OUT_LOAD   = 16'h0004;
  localparam logic [15:0] C_FLAGS_LOAD = 16'h0002;

  // Any opcode without an execute phase finishes at T2.
  function automatic logic is_nop(input logic [3:0] op);
    case (op)
      OP_LDA, OP_ADD, OP_SUB, OP_JMP, OP_JZ, OP_JC, OP_OUT, OP_HLT: is_nop = 1'b0;
      default:                                                      is_nop = 1'b1;
    endcase
  endfunction

  state_t      state_r;
  logic        out_valid_r;
  logic        halted_r;
  state_t      end_state_s;
  logic [15:0] ctrl_s;

  // Where an instruction goes after its last microstep.
  always_comb begin
    if (bus.run) begin
      end_state_s = ST_T0;
    end else begin
      end_state_s = ST_PAUSE;
    end
  end

  // Sequencer state, OUT wait flag and halt flag, all on the falling edge.
  always_ff @(negedge clk) begin
    if (rst) begin
      state_r     <= ST_PAUSE;
      out_valid_r <= 1'b0;
      halted_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_T0: state_r <= ST_T1;
        ST_T1: state_r <= ST_T2;
        ST_T2: begin
          if (is_nop(bus.opcode)) begin
            state_r <= end_state_s;
          end else begin
            state_r <= ST_T3;
          end
        end
        ST_T3: begin
          case (bus.opcode)
            OP_LDA, OP_ADD, OP_SUB: state_r <= ST_T4;
            OP_OUT: begin
              state_r     <= ST_T4;
              out_valid_r <= 1'b1;
            end
            OP_HLT: begin
              state_r  <= ST_HALT;
              halted_r <= 1'b1;
            end
            default: state_r <= end_state_s;
          endcase
        end
        ST_T4: begin
          // out_valid_r marks the OUT wait step; it holds until acked.
          if (out_valid_r) begin
            if (bus.out_ack) begin
              state_r     <= end_state_s;
              out_valid_r <= 1'b0;
            end else begin
              state_r <= ST_T4;
            end
          end else begin
            case (bus.opcode)
              OP_ADD, OP_SUB: state_r <= ST_T5;
              default:        state_r <= end_state_s;
            endcase
          end
        end
        ST_T5: state_r <= end_state_s;
        ST_PAUSE: begin
          if (bus.run || bus.step) begin
            state_r <= ST_T0;
          end else begin
            state_r <= ST_PAUSE;
          end
        end
        ST_HALT: state_r <= ST_HALT;
        default: begin
          state_r     <= ST_PAUSE;
          out_valid_r <= 1'b0;
          halted_r    <= 1'b0;
        end
      endcase
    end
  end

  // Control word decode; flags only matter in T3 of JZ/JC.
  always_comb begin
    ctrl_s = 16'h0000;
    case (state_r)
      ST_T0: ctrl_s = C_PC_EN | C_MEM_LOAD;
      ST_T1: ctrl_s = C_PC_INC;
      ST_T2: ctrl_s = C_MEM_EN | C_IR_LOAD;
      ST_T3: begin
        case (bus.opcode)
          OP_LDA, OP_ADD, OP_SUB: ctrl_s = C_IR_EN | C_MEM_LOAD;
          OP_JMP:                 ctrl_s = C_IR_EN | C_PC_LOAD;
          OP_JZ:                  ctrl_s = bus.flag_z ? (C_IR_EN | C_PC_LOAD) : 16'h0000;
          OP_JC:                  ctrl_s = bus.flag_c ? (C_IR_EN | C_PC_LOAD) : 16'h0000;
          OP_OUT:                 ctrl_s = C_A_EN | C_OUT_LOAD;
          OP_HLT:                 ctrl_s = C_HLT;
          default:                ctrl_s = 16'h0000;
        endcase
      end
      ST_T4: begin
        case (bus.opcode)
          OP_LDA:         ctrl_s = C_MEM_EN | C_A_LOAD;
          OP_ADD, OP_SUB: ctrl_s = C_MEM_EN | C_B_LOAD;
          default:        ctrl_s = 16'h0000;
        endcase
      end
      ST_T5: begin
        case (bus.opcode)
          OP_ADD:  ctrl_s = C_ADDER_EN | C_A_LOAD | C_FLAGS_LOAD;
          OP_SUB:  ctrl_s = C_ADDER_EN | C_A_LOAD | C_FLAGS_LOAD | C_ADDER_SUB;
          default: ctrl_s = 16'h0000;
        endcase
      end
      ST_PAUSE: ctrl_s = 16'h0000;
      ST_HALT:  ctrl_s = C_HLT;
      default:  ctrl_s = 16'h0000;
    endcase
  end

  assign bus.ctrl      = ctrl_s;
  assign bus.stage     = state_r;
  assign bus.out_valid = out_valid_r;
  assign bus.halted    = halted_r;

endmodule

// File: doc/sap_sequencer.md
# sap_sequencer

Variable-length microsequencer for the extended SAP datapath. It generates the 16-bit control word driving PC, MAR/RAM, IR, A, B, adder, flags and output registers. Execution ends early once an instruction's microsteps are done, and the block supports conditional jumps, an OUT handshake, halt, and run/single-step operation. It sits between the IR opcode and flag registers and every control input of the datapath.

## Interface

- No parameters. Control bit positions and opcodes are fixed constants, listed below.
- clk  in  1  Clock. State updates on the falling edge, so the control word is stable for datapath rising edges.
- rst  in  1  Synchronous, active-high reset.
- opcode  in  4  IR upper nibble. Valid from T3 onward.
- flag_z  in  1  Zero flag from the flags register.
- flag_c  in  1  Carry flag from the flags register.
- run  in  1  Level. 1 = free-run; 0 = pause between instructions.
- step  in  1  In PAUSE, 1 launches one instruction. Ignored in every other state.
- out_ack  in  1  Output consumer acknowledge.
- ctrl  out  16  Control word, combinational from state, opcode and flags.
- stage  out  3  Current state encoding.
- out_valid  out  1  High while waiting for out_ack.
- halted  out  1  High in HALT.

Control bits:
- HLT = 15
- PC_INC = 14
- PC_EN = 13
- PC_LOAD = 12
- MEM_LOAD = 11
- MEM_EN = 10
- IR_LOAD = 9
- IR_EN = 8
- A_LOAD = 7
- A_EN = 6
- B_LOAD = 5
- ADDER_SUB = 4
- ADDER_EN = 3
- OUT_LOAD = 2
- FLAGS_LOAD = 1
- Bit 0 is reserved and always 0.

Opcodes:
- LDA = 0000, ADD = 0001, SUB = 0010
- JMP = 0100, JZ = 0101, JC = 0110
- OUT = 1110, HLT = 1111
- All other opcodes are NOP.

## Operation

State encoding on stage: T0..T5 = 0..5, PAUSE = 6, HALT = 7.

Common fetch:
- T0: PC_EN, MEM_LOAD.
- T1: PC_INC.
- T2: MEM_EN, IR_LOAD. For NOP, T2 is the last step.

Execute steps ("end" = last step of the instruction):
- LDA: T3 IR_EN, MEM_LOAD; T4 MEM_EN, A_LOAD; end.
- ADD: T3 IR_EN, MEM_LOAD; T4 MEM_EN, B_LOAD; T5 ADDER_EN, A_LOAD, FLAGS_LOAD; end.
- SUB: as ADD, with ADDER_SUB also asserted in T5.
- JMP: T3 IR_EN, PC_LOAD; end.
- JZ / JC: T3 asserts IR_EN and PC_LOAD only if flag_z / flag_c is 1; otherwise ctrl = 0. End after T3.
- OUT: T3 A_EN, OUT_LOAD. T4 is the wait step: ctrl = 0, out_valid = 1, and the state holds until out_ack = 1 is sampled; then end.
- HLT: T3 ctrl = HLT bit; next state is HALT.

State transitions:
- After an end step: go to T0 if run = 1, else to PAUSE.
- PAUSE: ctrl = 0. Go to T0 when run = 1 or step = 1.
- HALT: ctrl = HLT bit and halted = 1. Only rst leaves HALT; run, step and out_ack are ignored.

Reset state: PAUSE, with ctrl = 0, stage = 6, out_valid = 0, halted = 0.

## Timing

- All state changes and rst sampling occur on the falling edge of clk.
- Instruction length in cycles, T0 to the next T0 with run = 1:
  - NOP: 3
  - JMP / JZ / JC: 4
  - LDA: 5
  - ADD / SUB: 6
  - OUT: 5 + n, where n is the number of extra wait cycles before out_ack.
- HLT takes 4 cycles, then the block stays in HALT permanently.
- PAUSE to T0 takes 1 edge after run or step is seen.
- step held high for k PAUSE visits launches k instructions; the bench drives single-cycle pulses.
- out_ack is sampled only in the OUT wait step.
  - out_ack already high on entry to the wait step means out_valid lasts exactly 1 cycle.
  - out_ack in any other state is ignored.
- Flags are read combinationally during T3 only. Changes to flag_z or flag_c after T3 have no effect.
- Opcode changes during T0–T2 have no effect on ctrl.
- Exactly one of PC_EN, MEM_EN, IR_EN, A_EN, ADDER_EN is high per cycle, or none; never two at once.
- rst has priority over every input, in any state including HALT and the OUT wait. On the next edge: PAUSE, all outputs at their reset values.
- run dropping mid-instruction does not stop it. The current instruction completes, then the block enters PAUSE.

## Test plan

- Reset, then run = 1, opcode = LDA: stage sequence 6,0,1,2,3,4,0. ctrl values 0x2800, 0x4000, 0x0600, 0x0900, 0x0480.
- ADD then SUB, run = 1: T5 ctrl = 0x008A for ADD and 0x009A for SUB. Each instruction takes 6 cycles.
- JZ with flag_z = 0, then JZ with flag_z = 1: T3 ctrl = 0x0000, then 0x1100. Each instruction takes 4 cycles.
- OUT with out_ack withheld for 3 cycles: T3 ctrl = 0x0044. out_valid is high for 4 cycles in T4. Return to T0 on the edge after out_ack.
- run = 0 and a 1-cycle step pulse with opcode = NOP: exactly one 3-cycle pass T0,T1,T2, then back to PAUSE. With no step, the block remains in PAUSE for 10 cycles with ctrl = 0.
- HLT reached, then run/step/out_ack toggled: ctrl stays 0x8000 and halted = 1. rst asserted in HALT, and separately mid-OUT-wait: PAUSE on the next edge, with out_valid = 0 and halted = 0.
